request_handler_2: RTL and testbench
====================================

REQUEST_HANDLER_2 -- requirements
Module: request_handler_2

Interface
REQ-001: The block SHALL have exactly one clock and one reset, with synchronous active-low reset: clk in 1 (rising edge); nRst in 1 (active-low, synchronous).
REQ-002: mem_busy  in  1  memory/Wishbone transaction in progress.
REQ-003: VGA_state  in  2  VGA phase: INACTIVE=2'b00, READY=2'b01, ACTIVE=2'b10; 2'b11 treated as INACTIVE.
REQ-004: CPU_enable  out  1  one-cycle pulse letting the CPU advance one instruction.
REQ-005: VGA_read  in  1;  VGA_adr  in  32;  data_to_VGA  out  32 (VGA read request, address, returned data).
REQ-006: CPU_instr_adr  in  32;  CPU_data_adr  in  32;  CPU_read  in  1;  CPU_write  in  1;  data_from_CPU  in  32;  CPU_sel  in  4.
REQ-007: instr_data_to_CPU  out  32;  data_to_CPU  out  32 (fetched instruction, loaded data).
REQ-008: data_from_mem  in  32;  mem_read  out  1;  mem_write  out  1;  adr_to_mem  out  32;  data_to_mem  out  32;  sel_to_mem  out  4.

Function
REQ-009: The block SHALL arbitrate one memory port among VGA, CPU instruction fetch and CPU data access; FSM states CPU_INSTR, CPU_DATA, CPU_DONE, plus a 1-bit in-flight flag and registered mem_busy (busy_q).
REQ-010: A transaction SHALL be issued while mem_busy=0 and SHALL complete on a mem_busy falling edge (busy_q=1, mem_busy=0).
REQ-011: While mem_busy=1, mem_read, mem_write, adr_to_mem, data_to_mem and sel_to_mem SHALL all be 0, combinationally.
REQ-012: VGA_state=ACTIVE with mem_busy=0: the port SHALL be routed to VGA combinationally (same cycle): mem_read=VGA_read, mem_write=0, adr_to_mem=VGA_adr, data_to_mem=0, sel_to_mem=4'b1111; the CPU FSM SHALL hold.
REQ-013: VGA completion SHALL register data_from_mem into data_to_VGA; data_to_VGA SHALL otherwise hold.
REQ-014: VGA_state=READY: an in-flight CPU transaction SHALL finish and capture normally; no new CPU transaction SHALL start.
REQ-015: CPU_INSTR, INACTIVE, mem_busy=0: mem_read=1, adr_to_mem=CPU_instr_adr, sel_to_mem=4'b1111, mem_write=0, data_to_mem=0; on completion capture instr_data_to_CPU, then go to CPU_DATA if CPU_read or CPU_write, else CPU_DONE.
REQ-016: CPU_DATA: adr_to_mem=CPU_data_adr, sel_to_mem=CPU_sel, mem_read=CPU_read, mem_write=CPU_write, data_to_mem=data_from_CPU (0 when not writing); on completion capture data_to_CPU on reads only, go to CPU_DONE.
REQ-017: CPU_read and CPU_write both 1 SHALL be serviced as a write.
REQ-018: CPU_DONE SHALL drive CPU_enable=1 for exactly one cycle, then return to CPU_INSTR; CPU_enable SHALL be 0 in every other state.
REQ-019: A mem_busy falling edge with no transaction in flight SHALL be ignored.

Reset
REQ-020: While nRst=0, outputs SHALL be forced combinationally to: CPU_enable=0, data_to_VGA=0, instr_data_to_CPU=0, data_to_CPU=0, mem_read=1, mem_write=0, adr_to_mem=0, data_to_mem=0, sel_to_mem=4'b1111.
REQ-021: At a rising clk with nRst=0, the FSM SHALL go to CPU_INSTR and clear the in-flight flag, busy_q and all data registers; a reset mid-transaction SHALL abandon it without capturing data.

Structure
REQ-022: A shared package SHALL hold VGA_state_t (INACTIVE/READY/ACTIVE) and the FSM state enum.
REQ-023: Output port muxing SHALL live in one sub-module, mem_port_mux; the FSM and capture registers stay in the top.

Verification
REQ-024: nRst=0 for one cycle -> mem_read=1, adr_to_mem=0, sel_to_mem=4'b1111; all other outputs 0.
REQ-025: VGA_state=ACTIVE, VGA_read=1, VGA_adr=32'hABCDE, mem_busy=0 -> within half a cycle mem_read=1, adr_to_mem=32'hABCDE, data_to_mem=0, sel_to_mem=4'b1111.
REQ-026: Then mem_busy=1 -> mem_read=0, mem_write=0, adr_to_mem=0, data_to_mem=0, sel_to_mem=0; mem_busy=0 with data_from_mem=32'h1234 -> data_to_VGA=32'h1234 on the next edge.
REQ-027: INACTIVE, CPU_instr_adr=32'h40, no data access, busy pulse returns 32'h00500093 -> instr_data_to_CPU=32'h00500093, then CPU_enable high exactly one cycle.
REQ-028: INACTIVE, CPU_write=1, CPU_data_adr=32'h80, data_from_CPU=32'hDEAD, CPU_sel=4'b0011 -> after the fetch, mem_write=1, adr_to_mem=32'h80, data_to_mem=32'hDEAD, sel_to_mem=4'b0011.
REQ-029: CPU fetch in flight, VGA_state=READY -> fetch completes and is captured, no new CPU request issued until VGA_state=INACTIVE.

Source files
------------

// File: rtl/request_handler_2_pkg.sv
// Shared types for the request_handler_2 memory-port arbiter.
//   VGA_state_t : VGA phase encoding as presented on the VGA_state input
//   cpu_state_t : CPU sequencing FSM states
//   port_sel_t  : which requester currently owns the memory port outputs
package request_handler_2_pkg;

    typedef enum logic [1:0] {
        INACTIVE = 2'b00,
        READY    = 2'b01,
        ACTIVE   = 2'b10
    } VGA_state_t;

    typedef enum logic [1:0] {
        CPU_INSTR = 2'b00,
        CPU_DATA  = 2'b01,
        CPU_DONE  = 2'b10
    } cpu_state_t;

    typedef enum logic [1:0] {
        PORT_IDLE  = 2'b00,
        PORT_VGA   = 2'b01,
        PORT_INSTR = 2'b10,
        PORT_DATA  = 2'b11
    } port_sel_t;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    // The unused encoding 2'b11 behaves like INACTIVE, so the CPU may start.
    function automatic logic cpu_may_start(input logic [1:0] vga_state);
        return (vga_state == INACTIVE) || (vga_state == 2'b11);
    endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Output steering for request_handler_2. Selects which requester drives the
// memory port and forces every output to its reset value while nRst_i is low.
// Ports:
//   nRst_i, mem_busy_i        : reset and memory-busy qualifiers
//   port_sel_i                : owner of the port this cycle
//   VGA_* / CPU_* inputs      : request fields of each requester
//   cpu_done_i                : FSM is in CPU_DONE
//   *_q_i                     : captured read data registers
//   mem_*_o, *_to_mem_o       : memory port
//   CPU_enable_o, data_to_*_o : requester-facing outputs
module mem_port_mux
    import request_handler_2_pkg::*;
(
    input  logic        nRst_i,
    input  logic        mem_busy_i,
    input  port_sel_t   port_sel_i,
    input  logic        VGA_read_i,
    input  logic [31:0] VGA_adr_i,
    input  logic [31:0] CPU_instr_adr_i,
    input  logic [31:0] CPU_data_adr_i,
    input  logic        CPU_read_i,
    input  logic        CPU_write_i,
    input  logic [31:0] data_from_CPU_i,
    input  logic [3:0]  CPU_sel_i,
    input  logic        cpu_done_i,
    input  logic [31:0] data_to_VGA_q_i,
    input  logic [31:0] instr_data_q_i,
    input  logic [31:0] data_to_CPU_q_i,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] adr_to_mem_o,
    output logic [31:0] data_to_mem_o,
    output logic [3:0]  sel_to_mem_o,
    output logic        CPU_enable_o,
    output logic [31:0] data_to_VGA_o,
    output logic [31:0] instr_data_to_CPU_o,
    output logic [31:0] data_to_CPU_o
);

    always_comb begin
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        adr_to_mem_o  = '0;
        data_to_mem_o = '0;
        sel_to_mem_o  = '0;
        if (!nRst_i) begin
            mem_read_o   = 1'b1;
            sel_to_mem_o = SEL_ALL;
        end else if (!mem_busy_i) begin
            case (port_sel_i)
                PORT_VGA: begin
                    mem_read_o   = VGA_read_i;
                    adr_to_mem_o = VGA_adr_i;
                    sel_to_mem_o = SEL_ALL;
                end
                PORT_INSTR: begin
                    mem_read_o   = 1'b1;
                    adr_to_mem_o = CPU_instr_adr_i;
                    sel_to_mem_o = SEL_ALL;
                end
                PORT_DATA: begin
                    // Read and write together is serviced as a write.
                    mem_read_o    = CPU_read_i & ~CPU_write_i;
                    mem_write_o   = CPU_write_i;
                    adr_to_mem_o  = CPU_data_adr_i;
                    sel_to_mem_o  = CPU_sel_i;
                    data_to_mem_o = CPU_write_i ? data_from_CPU_i : '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        CPU_enable_o        = nRst_i & cpu_done_i;
        data_to_VGA_o       = nRst_i ? data_to_VGA_q_i : '0;
        instr_data_to_CPU_o = nRst_i ? instr_data_q_i  : '0;
        data_to_CPU_o       = nRst_i ? data_to_CPU_q_i : '0;
    end

endmodule

// File: rtl/request_handler_2.sv
// Arbitrates one memory port between VGA reads, CPU instruction fetch and
// CPU data access. A transaction is issued while mem_busy is low and
// completes on the following mem_busy falling edge.
// Ports:
//   clk, nRst                      : clock, synchronous active-low reset
//   mem_busy, data_from_mem        : memory status and read data
//   VGA_state, VGA_read, VGA_adr   : VGA phase and read request
//   CPU_* , data_from_CPU          : CPU fetch/data request fields
//   CPU_enable                     : one-cycle step pulse to the CPU
//   data_to_VGA, instr_data_to_CPU, data_to_CPU : captured read data
//   mem_read, mem_write, adr_to_mem, data_to_mem, sel_to_mem : memory port
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CPU_INSTR | fetch instruction at CPU_instr_adr
// CPU_DATA  | load/store at CPU_data_adr
// CPU_DONE  | pulse CPU_enable for one cycle, then fetch again
module request_handler_2
    import request_handler_2_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic        mem_busy,
    input  logic [1:0]  VGA_state,
    output logic        CPU_enable,
    input  logic        VGA_read,
    input  logic [31:0] VGA_adr,
    output logic [31:0] data_to_VGA,
    input  logic [31:0] CPU_instr_adr,
    input  logic [31:0] CPU_data_adr,
    input  logic        CPU_read,
    input  logic        CPU_write,
    input  logic [31:0] data_from_CPU,
    input  logic [3:0]  CPU_sel,
    output logic [31:0] instr_data_to_CPU,
    output logic [31:0] data_to_CPU,
    input  logic [31:0] data_from_mem,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] adr_to_mem,
    output logic [31:0] data_to_mem,
    output logic [3:0]  sel_to_mem
);

    cpu_state_t  state_q, state_d;
    logic        inflight_q, inflight_d;
    logic        owner_vga_q, owner_vga_d;
    logic        busy_q;
    logic [31:0] data_to_VGA_q, data_to_VGA_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q, data_d;

    port_sel_t   port_sel;
    logic        req_now;
    logic        complete;
    logic        cpu_complete;
    logic        issue;

    always_comb begin
        port_sel = PORT_IDLE;
        if (VGA_state == ACTIVE) begin
            port_sel = PORT_VGA;
        end else if (cpu_may_start(VGA_state)) begin
            case (state_q)
                CPU_INSTR: port_sel = PORT_INSTR;
                CPU_DATA:  port_sel = PORT_DATA;
                default:   port_sel = PORT_IDLE;
            endcase
        end

        case (port_sel)
            PORT_VGA:   req_now = VGA_read;
            PORT_INSTR: req_now = 1'b1;
            PORT_DATA:  req_now = CPU_read | CPU_write;
            default:    req_now = 1'b0;
        endcase

        complete     = busy_q & ~mem_busy & inflight_q;
        cpu_complete = complete & ~owner_vga_q;
        // The completing cycle itself is not counted as a new issue, so a
        // request left on the port while the FSM advances is not tracked twice.
        issue        = ~mem_busy & req_now & ~complete;
    end

    always_comb begin
        state_d       = state_q;
        inflight_d    = inflight_q;
        owner_vga_d   = owner_vga_q;
        data_to_VGA_d = data_to_VGA_q;
        instr_d       = instr_q;
        data_d        = data_q;

        if (complete) begin
            inflight_d = 1'b0;
        end else if (issue) begin
            inflight_d  = 1'b1;
            owner_vga_d = (port_sel == PORT_VGA);
        end

        if (complete && owner_vga_q) begin
            data_to_VGA_d = data_from_mem;
        end

        case (state_q)
            CPU_INSTR: begin
                if (cpu_complete) begin
                    instr_d = data_from_mem;
                    state_d = (CPU_read | CPU_write) ? CPU_DATA : CPU_DONE;
                end
            end
            CPU_DATA: begin
                if (cpu_complete) begin
                    if (CPU_read && !CPU_write) begin
                        data_d = data_from_mem;
                    end
                    state_d = CPU_DONE;
                end else if (port_sel == PORT_DATA && !req_now && !inflight_q) begin
                    // Access request withdrawn before it was issued.
                    state_d = CPU_DONE;
                end
            end
            CPU_DONE: state_d = CPU_INSTR;
            default:  state_d = CPU_INSTR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q       <= CPU_INSTR;
            inflight_q    <= 1'b0;
            owner_vga_q   <= 1'b0;
            busy_q        <= 1'b0;
            data_to_VGA_q <= '0;
            instr_q       <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            owner_vga_q   <= owner_vga_d;
            busy_q        <= mem_busy;
            data_to_VGA_q <= data_to_VGA_d;
            instr_q       <= instr_d;
            data_q        <= data_d;
        end
    end

    mem_port_mux u_mem_port_mux (
        .nRst_i              (nRst),
        .mem_busy_i          (mem_busy),
        .port_sel_i          (port_sel),
        .VGA_read_i          (VGA_read),
        .VGA_adr_i           (VGA_adr),
        .CPU_instr_adr_i     (CPU_instr_adr),
        .CPU_data_adr_i      (CPU_data_adr),
        .CPU_read_i          (CPU_read),
        .CPU_write_i         (CPU_write),
        .data_from_CPU_i     (data_from_CPU),
        .CPU_sel_i           (CPU_sel),
        .cpu_done_i          (state_q == CPU_DONE),
        .data_to_VGA_q_i     (data_to_VGA_q),
        .instr_data_q_i      (instr_q),
        .data_to_CPU_q_i     (data_q),
        .mem_read_o          (mem_read),
        .mem_write_o         (mem_write),
        .adr_to_mem_o        (adr_to_mem),
        .data_to_mem_o       (data_to_mem),
        .sel_to_mem_o        (sel_to_mem),
        .CPU_enable_o        (CPU_enable),
        .data_to_VGA_o       (data_to_VGA),
        .instr_data_to_CPU_o (instr_data_to_CPU),
        .data_to_CPU_o       (data_to_CPU)
    );

endmodule

// File: tb/tb_request_handler_2.sv
module tb_request_handler_2;
    import request_handler_2_pkg::*;

    logic        clk = 1'b0;
    logic        nRst;
    logic        mem_busy;
    logic [1:0]  VGA_state;
    logic        CPU_enable;
    logic        VGA_read;
    logic [31:0] VGA_adr;
    logic [31:0] data_to_VGA;
    logic [31:0] CPU_instr_adr;
    logic [31:0] CPU_data_adr;
    logic        CPU_read;
    logic        CPU_write;
    logic [31:0] data_from_CPU;
    logic [3:0]  CPU_sel;
    logic [31:0] instr_data_to_CPU;
    logic [31:0] data_to_CPU;
    logic [31:0] data_from_mem;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] adr_to_mem;
    logic [31:0] data_to_mem;
    logic [3:0]  sel_to_mem;

    request_handler_2 dut (
        .clk               (clk),
        .nRst              (nRst),
        .mem_busy          (mem_busy),
        .VGA_state         (VGA_state),
        .CPU_enable        (CPU_enable),
        .VGA_read          (VGA_read),
        .VGA_adr           (VGA_adr),
        .data_to_VGA       (data_to_VGA),
        .CPU_instr_adr     (CPU_instr_adr),
        .CPU_data_adr      (CPU_data_adr),
        .CPU_read          (CPU_read),
        .CPU_write         (CPU_write),
        .data_from_CPU     (data_from_CPU),
        .CPU_sel           (CPU_sel),
        .instr_data_to_CPU (instr_data_to_CPU),
        .data_to_CPU       (data_to_CPU),
        .data_from_mem     (data_from_mem),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .adr_to_mem        (adr_to_mem),
        .data_to_mem       (data_to_mem),
        .sel_to_mem        (sel_to_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_run++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic exp_port(input string tag, input logic rd, input logic wr,
                            input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        sb_push({tag, ".mem_read"},    {31'b0, rd});
        sb_push({tag, ".mem_write"},   {31'b0, wr});
        sb_push({tag, ".adr_to_mem"},  adr);
        sb_push({tag, ".data_to_mem"}, dat);
        sb_push({tag, ".sel_to_mem"},  {28'b0, sel});
    endtask

    task automatic obs_port();
        sb_check({31'b0, mem_read});
        sb_check({31'b0, mem_write});
        sb_check(adr_to_mem);
        sb_check(data_to_mem);
        sb_check({28'b0, sel_to_mem});
    endtask

    task automatic exp_regs(input string tag, input logic en,
                            input logic [31:0] vga, input logic [31:0] ins,
                            input logic [31:0] dcpu);
        sb_push({tag, ".CPU_enable"},        {31'b0, en});
        sb_push({tag, ".data_to_VGA"},       vga);
        sb_push({tag, ".instr_data_to_CPU"}, ins);
        sb_push({tag, ".data_to_CPU"},       dcpu);
    endtask

    task automatic obs_regs();
        sb_check({31'b0, CPU_enable});
        sb_check(data_to_VGA);
        sb_check(instr_data_to_CPU);
        sb_check(data_to_CPU);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue edge, busy for 'cycles' edges, then falling busy with read data;
    // returns one time unit after the capture edge.
    task automatic mem_pulse(input logic [31:0] rdata, input int cycles);
        tick();
        mem_busy = 1'b1;
        repeat (cycles) tick();
        mem_busy      = 1'b0;
        data_from_mem = rdata;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst          = 1'b0;
        mem_busy      = 1'b0;
        VGA_state     = INACTIVE;
        VGA_read      = 1'b0;
        VGA_adr       = '0;
        CPU_instr_adr = 32'h100;
        CPU_data_adr  = '0;
        CPU_read      = 1'b0;
        CPU_write     = 1'b0;
        data_from_CPU = '0;
        CPU_sel       = '0;
        data_from_mem = '0;

        // Reset values
        exp_port("rst", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        exp_regs("rst", 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        obs_port();
        obs_regs();

        // VGA routing, same cycle
        VGA_state = ACTIVE;
        VGA_read  = 1'b1;
        VGA_adr   = 32'hABCDE;
        tick();
        nRst = 1'b1;
        exp_port("vga_route", 1'b1, 1'b0, 32'hABCDE, 32'h0, 4'hF);
        #1 obs_port();

        // Busy blanks the port, falling edge captures VGA data
        tick();
        mem_busy = 1'b1;
        exp_port("vga_busy", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 obs_port();
        tick();
        tick();
        mem_busy      = 1'b0;
        data_from_mem = 32'h1234;
        VGA_read      = 1'b0;
        exp_regs("vga_done", 1'b0, 32'h1234, 32'h0, 32'h0);
        tick();
        obs_regs();

        // Falling edge with nothing in flight is ignored
        mem_busy = 1'b1;
        tick();
        mem_busy      = 1'b0;
        data_from_mem = 32'hFFFF;
        sb_push("vga_spurious.data_to_VGA", 32'h1234);
        tick();
        sb_check(data_to_VGA);

        // Instruction fetch without data access
        VGA_state     = INACTIVE;
        CPU_instr_adr = 32'h40;
        exp_port("fetch", 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        #1 obs_port();
        mem_pulse(32'h00500093, 2);
        exp_regs("fetch_done", 1'b1, 32'h1234, 32'h00500093, 32'h0);
        obs_regs();
        tick();
        exp_regs("fetch_en_drop", 1'b0, 32'h1234, 32'h00500093, 32'h0);
        obs_regs();

        // Fetch followed by write
        CPU_instr_adr = 32'h44;
        CPU_write     = 1'b1;
        CPU_data_adr  = 32'h80;
        data_from_CPU = 32'hDEAD;
        CPU_sel       = 4'b0011;
        exp_port("fetch2", 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        #1 obs_port();
        mem_pulse(32'h00A00113, 1);
        exp_port("cpu_write", 1'b0, 1'b1, 32'h80, 32'hDEAD, 4'b0011);
        exp_regs("fetch2_done", 1'b0, 32'h1234, 32'h00A00113, 32'h0);
        obs_port();
        obs_regs();
        mem_pulse(32'h5555, 1);
        exp_regs("write_done", 1'b1, 32'h1234, 32'h00A00113, 32'h0);
        obs_regs();
        tick();

        // Fetch followed by read
        CPU_write     = 1'b0;
        CPU_read      = 1'b1;
        CPU_data_adr  = 32'h84;
        CPU_sel       = 4'hF;
        CPU_instr_adr = 32'h48;
        mem_pulse(32'h00B00213, 1);
        exp_port("cpu_read", 1'b1, 1'b0, 32'h84, 32'h0, 4'hF);
        obs_port();
        mem_pulse(32'hCAFEF00D, 1);
        exp_regs("read_done", 1'b1, 32'h1234, 32'h00B00213, 32'hCAFEF00D);
        obs_regs();
        tick();

        // Read and write together act as a write
        CPU_write     = 1'b1;
        data_from_CPU = 32'hBEEF;
        CPU_data_adr  = 32'h88;
        CPU_sel       = 4'hC;
        mem_pulse(32'h00C00293, 1);
        exp_port("cpu_rw", 1'b0, 1'b1, 32'h88, 32'hBEEF, 4'hC);
        obs_port();
        mem_pulse(32'h11112222, 1);
        exp_regs("rw_done", 1'b1, 32'h1234, 32'h00C00293, 32'hCAFEF00D);
        obs_regs();
        tick();

        // READY: in-flight fetch completes, nothing new starts
        CPU_read      = 1'b0;
        CPU_write     = 1'b0;
        CPU_instr_adr = 32'h4C;
        tick();
        VGA_state = READY;
        mem_busy  = 1'b1;
        exp_port("ready_busy", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 obs_port();
        tick();
        tick();
        mem_busy      = 1'b0;
        data_from_mem = 32'h00700193;
        tick();
        exp_regs("ready_capture", 1'b1, 32'h1234, 32'h00700193, 32'hCAFEF00D);
        obs_regs();
        tick();
        exp_port("ready_hold", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_regs("ready_hold", 1'b0, 32'h1234, 32'h00700193, 32'hCAFEF00D);
        obs_port();
        obs_regs();
        tick();
        tick();
        exp_port("ready_hold2", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        obs_port();
        VGA_state = INACTIVE;
        exp_port("ready_release", 1'b1, 1'b0, 32'h4C, 32'h0, 4'hF);
        #1 obs_port();

        // Reset in the middle of a fetch abandons it
        tick();
        mem_busy = 1'b1;
        tick();
        tick();
        mem_busy      = 1'b0;
        data_from_mem = 32'hDEADBEEF;
        nRst          = 1'b0;
        exp_port("rst_mid", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        exp_regs("rst_mid", 1'b0, 32'h0, 32'h0, 32'h0);
        #1 obs_port();
        obs_regs();
        tick();
        nRst     = 1'b1;
        mem_busy = 1'b1;
        exp_regs("rst_abandon", 1'b0, 32'h0, 32'h0, 32'h0);
        #1 obs_regs();
        tick();
        mem_busy      = 1'b0;
        data_from_mem = 32'h0BADF00D;
        tick();
        exp_regs("rst_no_inflight", 1'b0, 32'h0, 32'h0, 32'h0);
        obs_regs();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
